// File: rtl/data_format_adapter_ram_arbiter.sv
// Shares the lookahead RAM write and read ports between two clients, with a tag pipeline returning read data to its owner.
// Define DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN for fixed priority (a over b, r0 over r1); the default is round-robin.
module data_format_adapter_ram_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 1,
   parameter int READ_LATENCY  = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDRESS_WIDTH-1:0] a_address,
   input  logic [DATA_WIDTH-1:0]    a_writedata,
   input  logic                     a_write,
   output logic                     a_waitrequest,
   input  logic [ADDRESS_WIDTH-1:0] b_address,
   input  logic [DATA_WIDTH-1:0]    b_writedata,
   input  logic                     b_write,
   output logic                     b_waitrequest,
   input  logic [ADDRESS_WIDTH-1:0] r0_address,
   input  logic                     r0_read,
   output logic                     r0_waitrequest,
   output logic [DATA_WIDTH-1:0]    r0_readdata,
   output logic                     r0_readdatavalid,
   input  logic [ADDRESS_WIDTH-1:0] r1_address,
   input  logic                     r1_read,
   output logic                     r1_waitrequest,
   output logic [DATA_WIDTH-1:0]    r1_readdata,
   output logic                     r1_readdatavalid,
   output logic [ADDRESS_WIDTH-1:0] ram_wr_address,
   output logic [DATA_WIDTH-1:0]    ram_wr_writedata,
   output logic                     ram_wr_write,
   input  logic                     ram_wr_waitrequest,
   output logic [ADDRESS_WIDTH-1:0] ram_rd_address,
   input  logic [DATA_WIDTH-1:0]    ram_rd_readdata
);

   logic                     wr_gnt_a_s;
   logic                     wr_gnt_b_s;
   logic                     wr_acc_s;
   logic                     rd_gnt_0_s;
   logic                     rd_gnt_1_s;
   logic                     rd_acc_s;
   logic [ADDRESS_WIDTH-1:0] rd_addr_hold_r;
   logic [READ_LATENCY-1:0]  tag_valid_r;
   logic [READ_LATENCY-1:0]  tag_owner_r;

`ifdef DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN
   assign wr_gnt_a_s = a_write;
   assign wr_gnt_b_s = b_write & ~a_write;
   assign rd_gnt_0_s = r0_read;
   assign rd_gnt_1_s = r1_read & ~r0_read;
`else
   // Pointers hold the last winner: 1'b1 means b / r1 won most recently.
   logic wlast_r;
   logic rlast_r;

   assign wr_gnt_a_s = a_write & (~b_write | wlast_r);
   assign wr_gnt_b_s = b_write & (~a_write | ~wlast_r);
   assign rd_gnt_0_s = r0_read & (~r1_read | rlast_r);
   assign rd_gnt_1_s = r1_read & (~r0_read | ~rlast_r);

   // Round-robin pointers advance only when a transfer is actually accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wlast_r <= 1'b1;
         rlast_r <= 1'b1;
      end else begin
         if (wr_acc_s) begin
            wlast_r <= wr_gnt_b_s;
         end
         if (rd_acc_s) begin
            rlast_r <= rd_gnt_1_s;
         end
      end
   end
`endif

   // Grants are pure arbitration; reset_n only gates what leaves the block.
   assign wr_acc_s = (wr_gnt_a_s | wr_gnt_b_s) & ~ram_wr_waitrequest;
   assign rd_acc_s = rd_gnt_0_s | rd_gnt_1_s;

   assign a_waitrequest    = ~reset_n | (a_write & ~(wr_gnt_a_s & ~ram_wr_waitrequest));
   assign b_waitrequest    = ~reset_n | (b_write & ~(wr_gnt_b_s & ~ram_wr_waitrequest));
   assign ram_wr_write     = reset_n & wr_acc_s;
   assign ram_wr_address   = wr_gnt_b_s ? b_address   : a_address;
   assign ram_wr_writedata = wr_gnt_b_s ? b_writedata : a_writedata;

   assign r0_waitrequest = ~reset_n | (r0_read & ~rd_gnt_0_s);
   assign r1_waitrequest = ~reset_n | (r1_read & ~rd_gnt_1_s);

   // Read address comes from the granted client and otherwise holds the last one.
   always_comb begin
      ram_rd_address = rd_addr_hold_r;
      if (reset_n && rd_gnt_0_s) begin
         ram_rd_address = r0_address;
      end else if (reset_n && rd_gnt_1_s) begin
         ram_rd_address = r1_address;
      end else begin
         ram_rd_address = rd_addr_hold_r;
      end
   end

   // Remember the last granted read address for idle cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr_hold_r <= {ADDRESS_WIDTH{1'b0}};
      end else if (rd_acc_s) begin
         rd_addr_hold_r <= rd_gnt_0_s ? r0_address : r1_address;
      end
   end

   // Tag pipeline aligned with the RAM read latency; owner 1'b1 means r1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_valid_r <= {READ_LATENCY{1'b0}};
         tag_owner_r <= {READ_LATENCY{1'b0}};
      end else begin
         tag_valid_r[0] <= rd_acc_s;
         tag_owner_r[0] <= rd_gnt_1_s;
         for (int k = 1; k < READ_LATENCY; k++) begin
            tag_valid_r[k] <= tag_valid_r[k-1];
            tag_owner_r[k] <= tag_owner_r[k-1];
         end
      end
   end

   assign r0_readdatavalid = tag_valid_r[READ_LATENCY-1] & ~tag_owner_r[READ_LATENCY-1];
   assign r1_readdatavalid = tag_valid_r[READ_LATENCY-1] &  tag_owner_r[READ_LATENCY-1];
   assign r0_readdata      = ram_rd_readdata;
   assign r1_readdata      = ram_rd_readdata;

endmodule

// File: tb/tb_data_format_adapter_ram_arbiter.sv
// Randomised and directed bench for data_format_adapter_ram_arbiter, checked against a queue-based model.
module tb_data_format_adapter_ram_arbiter;
   localparam int DW = 8;
   localparam int AW = 1;
   localparam int L  = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] a_address = '0, b_address = '0, r0_address = '0, r1_address = '0;
   logic [DW-1:0] a_writedata = '0, b_writedata = '0;
   logic          a_write = 1'b0, b_write = 1'b0, r0_read = 1'b0, r1_read = 1'b0;
   logic          ram_wr_waitrequest = 1'b0;
   logic          a_waitrequest, b_waitrequest, r0_waitrequest, r1_waitrequest;
   logic [DW-1:0] r0_readdata, r1_readdata, ram_wr_writedata, ram_rd_readdata;
   logic          r0_readdatavalid, r1_readdatavalid, ram_wr_write;
   logic [AW-1:0] ram_wr_address, ram_rd_address;

   int vectors = 0;
   int fails   = 0;

   data_format_adapter_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_address(a_address), .a_writedata(a_writedata), .a_write(a_write), .a_waitrequest(a_waitrequest),
      .b_address(b_address), .b_writedata(b_writedata), .b_write(b_write), .b_waitrequest(b_waitrequest),
      .r0_address(r0_address), .r0_read(r0_read), .r0_waitrequest(r0_waitrequest),
      .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
      .r1_address(r1_address), .r1_read(r1_read), .r1_waitrequest(r1_waitrequest),
      .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
      .ram_wr_address(ram_wr_address), .ram_wr_writedata(ram_wr_writedata), .ram_wr_write(ram_wr_write),
      .ram_wr_waitrequest(ram_wr_waitrequest),
      .ram_rd_address(ram_rd_address), .ram_rd_readdata(ram_rd_readdata)
   );

   always #5 clk = ~clk;

   // Small RAM with read-after-write visibility: data for an address presented in cycle n appears in n+L
   logic [DW-1:0] mem [0:1] = '{8'h00, 8'h00};
   logic [AW-1:0] rp  [0:L-1] = '{default: '0};
   assign ram_rd_readdata = mem[rp[L-1]];
   initial forever begin
      @(posedge clk);
      if (ram_wr_write) mem[ram_wr_address] <= ram_wr_writedata;
      rp[0] <= ram_rd_address;
      for (int k = 1; k < L; k++) rp[k] <= rp[k-1];
   end

   // Behavioural model: last winners, held read address, queue of due responses
   typedef struct { int due; logic owner; } resp_t;
   resp_t q[$];
   logic wl_m = 1'b1, rl_m = 1'b1;
   logic [AW-1:0] rh_m = '0;
   logic a_pend = 1'b0, b_pend = 1'b0, r0_pend = 1'b0, r1_pend = 1'b0;
   int cyc = 0;

   function automatic void arb(input logic ra, input logic rb, input logic last_b,
                               output logic ga, output logic gb);
`ifdef DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN
      ga = ra;
      gb = rb && !ra && (last_b || !last_b);
`else
      if (ra && rb) begin
         ga = last_b;
         gb = !last_b;
      end else begin
         ga = ra;
         gb = rb;
      end
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
      end
   endtask

   initial forever begin : mdl
      logic ga, gb, g0, g1;
      @(posedge clk);
      if (!reset_n) begin
         q.delete(); wl_m = 1'b1; rl_m = 1'b1; rh_m = '0;
         a_pend = 1'b0; b_pend = 1'b0; r0_pend = 1'b0; r1_pend = 1'b0;
      end else begin
         arb(a_write, b_write, wl_m, ga, gb);
         arb(r0_read, r1_read, rl_m, g0, g1);
         a_pend  = a_write && !(ga && !ram_wr_waitrequest);
         b_pend  = b_write && !(gb && !ram_wr_waitrequest);
         r0_pend = r0_read && !g0;
         r1_pend = r1_read && !g1;
         if (!ram_wr_waitrequest && (ga || gb)) wl_m = gb;
         if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
         if (g0 || g1) begin
            q.push_back('{cyc + L, g1});
            rl_m = g1;
            rh_m = g0 ? r0_address : r1_address;
         end
      end
      cyc++;
   end

   initial forever begin
      @(negedge reset_n);
      q.delete(); wl_m = 1'b1; rl_m = 1'b1; rh_m = '0;
   end

   // Per-cycle comparison of every meaningful output against the model
   initial forever begin : cmp
      logic ga, gb, g0, g1, wok, ev0, ev1;
      logic [AW-1:0] era;
      @(negedge clk);
      arb(a_write, b_write, wl_m, ga, gb);
      arb(r0_read, r1_read, rl_m, g0, g1);
      wok = reset_n && !ram_wr_waitrequest;
      chk("a_waitrequest", a_waitrequest, !reset_n || (a_write && !(ga && wok)));
      chk("b_waitrequest", b_waitrequest, !reset_n || (b_write && !(gb && wok)));
      chk("ram_wr_write", ram_wr_write, wok && (ga || gb));
      if (wok && (ga || gb)) begin
         chk("ram_wr_address", ram_wr_address, gb ? b_address : a_address);
         chk("ram_wr_writedata", ram_wr_writedata, gb ? b_writedata : a_writedata);
      end
      chk("r0_waitrequest", r0_waitrequest, !reset_n || (r0_read && !g0));
      chk("r1_waitrequest", r1_waitrequest, !reset_n || (r1_read && !g1));
      era = (reset_n && g0) ? r0_address : ((reset_n && g1) ? r1_address : rh_m);
      chk("ram_rd_address", ram_rd_address, era);
      ev0 = q.size() > 0 && q[0].due == cyc && !q[0].owner;
      ev1 = q.size() > 0 && q[0].due == cyc &&  q[0].owner;
      chk("r0_readdatavalid", r0_readdatavalid, ev0);
      chk("r1_readdatavalid", r1_readdatavalid, ev1);
      if (ev0) chk("r0_readdata", r0_readdata, ram_rd_readdata);
      if (ev1) chk("r1_readdata", r1_readdata, ram_rd_readdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      a_write = 1'b0; b_write = 1'b0; r0_read = 1'b0; r1_read = 1'b0; ram_wr_waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int c0, c1, both;
      logic [7:0] exp;

      // Reset held for three cycles, then a single write accepted at once
      for (int i = 0; i < 3; i++) begin
         tick();
         a_write = 1'b1;
         settle();
         chk("rst_a_wait", a_waitrequest, 1'b1);
         chk("rst_b_wait", b_waitrequest, 1'b1);
         chk("rst_r0_wait", r0_waitrequest, 1'b1);
         chk("rst_wr", ram_wr_write, 1'b0);
         chk("rst_rdv", {r0_readdatavalid, r1_readdatavalid}, 2'b00);
         chk("rst_rd_addr", ram_rd_address, 1'b0);
      end
      tick();
      reset_n = 1'b1; a_write = 1'b1; a_address = 1'b1; a_writedata = 8'h33;
      settle();
      chk("rel_wr", ram_wr_write, 1'b1);
      chk("rel_a_wait", a_waitrequest, 1'b0);
      chk("rel_data", ram_wr_writedata, 8'h33);

      // Write contention
      do_reset();
      tick();
      a_write = 1'b1; b_write = 1'b1; a_address = 1'b0; b_address = 1'b1;
      a_writedata = 8'h11; b_writedata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
`ifdef DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN
         exp = 8'h11;
         chk("contend_b_wait", b_waitrequest, 1'b1);
`else
         exp = (i % 2 == 1) ? 8'h22 : 8'h11;
`endif
         chk("contend_data", ram_wr_writedata, exp);
         chk("contend_wr", ram_wr_write, 1'b1);
         tick();
      end
      idle_inputs();

      // RAM busy for five cycles, accepted on the sixth with the pointer untouched
      do_reset();
      tick();
      a_write = 1'b1; a_address = 1'b0; a_writedata = 8'h44; ram_wr_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("busy_a_wait", a_waitrequest, 1'b1);
         chk("busy_wr", ram_wr_write, 1'b0);
         tick();
      end
      ram_wr_waitrequest = 1'b0; b_write = 1'b1; b_address = 1'b1; b_writedata = 8'h55;
      settle();
      chk("busy_acc_wr", ram_wr_write, 1'b1);
      chk("busy_acc_data", ram_wr_writedata, 8'h44);
      chk("busy_b_wait", b_waitrequest, 1'b1);
      tick();
      a_write = 1'b0;
      settle();
      chk("busy_b_data", ram_wr_writedata, 8'h55);
      tick();
      idle_inputs();

      // Read routing: both readers for six cycles
      do_reset();
      tick();
      r0_read = 1'b1; r1_read = 1'b1; r0_address = 1'b0; r1_address = 1'b1;
      c0 = 0; c1 = 0; both = 0;
      for (int i = 0; i < 12; i++) begin
         settle();
         if (i == 2) chk("rd_first_pulse", {r0_readdatavalid, r1_readdatavalid}, 2'b10);
         if (r0_readdatavalid) c0++;
         if (r1_readdatavalid) c1++;
         if (r0_readdatavalid && r1_readdatavalid) both++;
         tick();
         if (i == 5) begin
            r0_read = 1'b0; r1_read = 1'b0;
         end
      end
`ifdef DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN
      chk("rd_cnt0", c0, 6);
      chk("rd_cnt1", c1, 0);
`else
      chk("rd_cnt0", c0, 3);
      chk("rd_cnt1", c1, 3);
`endif
      chk("rd_both", both, 0);

      // Read-after-write to the same address in one cycle
      do_reset();
      tick();
      a_write = 1'b1; a_address = 1'b0; a_writedata = 8'h5A; r0_read = 1'b1; r0_address = 1'b0;
      settle();
      chk("raw_wr", ram_wr_write, 1'b1);
      chk("raw_r0_wait", r0_waitrequest, 1'b0);
      tick();
      idle_inputs();
      tick();
      settle();
      chk("raw_valid", r0_readdatavalid, 1'b1);
      chk("raw_data", r0_readdata, 8'h5A);
      chk("raw_r1_valid", r1_readdatavalid, 1'b0);

      // Reset pulsed while an r1 read is in flight
      do_reset();
      tick();
      r1_read = 1'b1; r1_address = 1'b1;
      settle();
      chk("mid_r1_wait", r1_waitrequest, 1'b0);
      tick();
      r1_read = 1'b0; reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("mid_no_valid", r1_readdatavalid, 1'b0);
         tick();
      end

      // Random traffic honouring the hold-while-stalled rule
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 249) == 0) reset_n = 1'b0;
         if (!a_pend) begin
            a_write = ($urandom_range(0, 99) < 55); a_address = 1'($urandom); a_writedata = 8'($urandom);
         end
         if (!b_pend) begin
            b_write = ($urandom_range(0, 99) < 55); b_address = 1'($urandom); b_writedata = 8'($urandom);
         end
         if (!r0_pend) begin
            r0_read = ($urandom_range(0, 99) < 55); r0_address = 1'($urandom);
         end
         if (!r1_pend) begin
            r1_read = ($urandom_range(0, 99) < 55); r1_address = 1'($urandom);
         end
         ram_wr_waitrequest = ($urandom_range(0, 7) == 0);
      end
      tick();
      reset_n = 1'b1;
      idle_inputs();
      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/data_format_adapter_ram_arbiter.md
# data_format_adapter_ram_arbiter

Two-requester arbiter that shares the single write port and single read port of the data-format-adapter lookahead RAM between two internal clients (e.g. packer and unpacker). Writes and reads are arbitrated independently, one grant per port per cycle. Read responses return through a tag pipeline matched to the RAM read latency, so each client receives only its own data. Sits between the adapter datapath and the RAM instance; the RAM's own lookahead bypass still covers read-after-write.

## Interface
- DATA_WIDTH, 8, data width of RAM word
- ADDRESS_WIDTH, 1, RAM address width
- READ_LATENCY, 2, RAM cycles from address presented to readdata valid (≥1)

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_address / b_address  in  ADDRESS_WIDTH  write-client address
- a_writedata / b_writedata  in  DATA_WIDTH  write-client data
- a_write / b_write  in  1  write request
- a_waitrequest / b_waitrequest  out  1  write stalled; transfer accepted on a cycle with write=1, waitrequest=0
- r0_address / r1_address  in  ADDRESS_WIDTH  read-client address
- r0_read / r1_read  in  1  read request
- r0_waitrequest / r1_waitrequest  out  1  read stalled
- r0_readdata / r1_readdata  out  DATA_WIDTH  both driven from ram_rd_readdata
- r0_readdatavalid / r1_readdatavalid  out  1  response for this client, one pulse per accepted read
- ram_wr_address  out  ADDRESS_WIDTH; ram_wr_writedata  out  DATA_WIDTH; ram_wr_write  out  1
- ram_wr_waitrequest  in  1  RAM busy (reset/clear)
- ram_rd_address  out  ADDRESS_WIDTH; ram_rd_readdata  in  DATA_WIDTH

## Operation
- Write arbiter: round-robin. One requester → granted. Both → the one not granted last. Grant is combinational in the same cycle; the loser sees waitrequest=1.
- ram_wr_waitrequest=1 → both write waitrequests=1 (if requesting), ram_wr_write=0, write pointer held.
- ram_wr_* carry the granted client's address/data. ram_wr_write=1 only for an accepted transfer.
- Write pointer `wlast` updates only on an accepted write.
- Read arbiter: identical round-robin with its own pointer `rlast`. Reads are never stalled by ram_wr_waitrequest. Granted address goes to ram_rd_address; with no grant, ram_rd_address holds its last value.
- Tag pipeline: READ_LATENCY stages of {valid, owner}. Stage 0 is loaded on each accepted read; stages shift every cycle. Output stage drives rN_readdatavalid = valid && owner==N.
- Clients must not drop a request while stalled; address/data are held by the client. The arbiter stores no request.
- Read and write to the same address in one cycle are both granted. Freshness is provided by the RAM lookahead bypass, not by this block.

## Timing
- Reset (reset_n=0, async): wlast=rlast=B/r1 (A/r0 wins first tie), tag pipeline cleared. While reset_n=0: all waitrequests=1, ram_wr_write=0, readdatavalid=0, ram_rd_address=0.
- Write: 0-cycle arbitration latency. Throughput is 1 write/cycle across both clients.
- Read: accepted in cycle n → rN_readdatavalid=1 with data in cycle n+READ_LATENCY. Throughput is 1 read/cycle; back-to-back responses have no bubble.
- Reset asserted mid-operation: in-flight tags are discarded and no readdatavalid pulses follow.
- Pointer updates take effect from the next cycle.

## Configuration
- DATA_FORMAT_ADAPTER_RAM_ARB_FIXED_PRIO_EN defined: both arbiters use fixed priority, a over b and r0 over r1. wlast/rlast are not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → all waitrequests=1, ram_wr_write=0, readdatavalid=0. Release → a_write=1 accepted in the first cycle with ram_wr_waitrequest=0.
- Write contention: a_write=b_write=1 for 4 cycles with data 0x11/0x22 → ram_wr_writedata sequence 0x11,0x22,0x11,0x22. With FIXED_PRIO_EN: 0x11 ×4 and b_waitrequest=1 throughout.
- RAM busy: ram_wr_waitrequest=1 for 5 cycles while a_write=1 → a_waitrequest=1 and ram_wr_write=0 for 5 cycles. Accepted on cycle 6; pointer unchanged.
- Read routing: r0_read and r1_read continuously for 6 cycles, READ_LATENCY=2 → alternating r0/r1 readdatavalid starting 2 cycles after the first grant. Exactly 3 pulses each, no simultaneous pulses.
- Read-after-write: a writes 0x5A to address 0 in cycle n while r0 reads address 0 in cycle n → r0_readdata=0x5A with r0_readdatavalid in cycle n+2.
- Mid-flight reset: r1 read accepted, reset_n pulsed low in the next cycle → no r1_readdatavalid afterwards.
